// File: rtl/dma_mover.sv
// Single-word DMA copy engine: reads a word at src_addr and writes it to dst_addr.
// Pulses dma_en per committed word so the address generator steps.
module dma_mover #(
  parameter int         ADDR_W = 32,
  parameter int         DATA_W = 32,
  parameter logic [3:0] AXI_ID = 4'd0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              xfer_req,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  output logic              dma_en,
  output logic              busy,
  output logic [31:0]       words_done,
  output logic              bus_err,
  output logic [3:0]        arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [3:0]        awid,
  output logic [ADDR_W-1:0] awaddr,
  output logic [7:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  typedef enum logic [2:0] {
    IDLE, AR, R, WR, B, STEP, SETTLE
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] araddr_q;
  logic [ADDR_W-1:0] awaddr_q;
  logic [DATA_W-1:0] buf_q;
  logic              aw_done;
  logic              w_done;
  logic              aw_fire;
  logic              w_fire;
  logic              enter_ar;
  logic              r_fire;
  logic              b_fire;

  assign arid    = AXI_ID;
  assign awid    = AXI_ID;
  assign arlen   = 8'd0;
  assign awlen   = 8'd0;
  assign arsize  = 3'b010;
  assign awsize  = 3'b010;
  assign arburst = 2'b01;
  assign awburst = 2'b01;
  assign wstrb   = 4'hF;
  assign wlast   = wvalid;

  assign araddr  = araddr_q;
  assign awaddr  = awaddr_q;
  assign wdata   = buf_q;

  // Valids/readies decode straight from state so reset drops them at once
  assign arvalid = (state_q == AR);
  assign rready  = (state_q == R);
  assign awvalid = (state_q == WR) && !aw_done;
  assign wvalid  = (state_q == WR) && !w_done;
  assign bready  = (state_q == B);
  assign dma_en  = (state_q == STEP);
  assign busy    = (state_q != IDLE);

  assign aw_fire  = awvalid && awready;
  assign w_fire   = wvalid && wready;
  assign r_fire   = rready && rvalid;
  assign b_fire   = bready && bvalid;
  assign enter_ar = (state_d == AR) && (state_q != AR);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (xfer_req) state_d = AR;
      AR:      if (arready) state_d = R;
      R:       if (rvalid) state_d = WR;
      WR: begin
        if ((aw_done || aw_fire) && (w_done || w_fire))
          state_d = B;
      end
      B:       if (bvalid) state_d = STEP;
      STEP:    state_d = SETTLE;
      SETTLE:  state_d = xfer_req ? AR : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      araddr_q   <= '0;
      awaddr_q   <= '0;
      buf_q      <= '0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      words_done <= '0;
      bus_err    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (enter_ar)
        araddr_q <= src_addr;
      if (r_fire) begin
        buf_q    <= rdata;
        awaddr_q <= dst_addr;
      end
      // Per-channel done flags self-clear once WR is left
      aw_done <= (state_q == WR) && (aw_done || aw_fire);
      w_done  <= (state_q == WR) && (w_done || w_fire);
      if (state_q == IDLE && xfer_req) begin
        words_done <= '0;
        bus_err    <= 1'b0;
      end else begin
        if (state_q == STEP)
          words_done <= words_done + 32'd1;
        if ((r_fire && rresp != 2'b00) || (b_fire && bresp != 2'b00))
          bus_err <= 1'b1;
      end
    end
  end

endmodule
